lstm_state_buffer: RTL

- Capture side of the LSTM recurrent loop: stores per-neuron cell state C_t and hidden output h_t that the time-multiplexed LSTM node emits with its status stream.
- Replays C_{t-1} and h_{t-1} in neuron order for the next timestep:
  - C_{t-1} goes to the node's recurrent input.
  - h_{t-1} goes to the gate matrix-vector unit.
- Ping-pong double bank:
  - the write bank fills with timestep t;
  - the read bank drains timestep t-1;
  - the banks swap when both sides finish.

---
 rtl/lstm_state_buffer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lstm_state_buffer.sv
// Ping-pong C/h state buffer for the LSTM recurrent loop. The write bank captures timestep t
// while the read bank replays t-1. Optional stall counter: define LSTM_STATE_BUF_PERF_EN.
//   state     | meaning
//   S_INIT    | zero bank readable, nothing written yet this timestep
//   S_RUN     | both sides active
//   S_WAIT_RD | write side done, draining the read bank
//   S_WAIT_WR | read side drained, waiting for LAST
//   S_SWAP    | toggle banks, clear pointers, bump timestep
module lstm_state_buffer #(
    parameter int XLEN        = 16,
    parameter int NUM_NEURONS = 8,
    parameter int ADDR_W      = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        wr_status,
    input  logic [XLEN-1:0]   wr_c,
    input  logic [XLEN-1:0]   wr_h,
    input  logic              rd_en,
    output logic [XLEN-1:0]   rd_c,
    output logic [XLEN-1:0]   rd_h,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              ts_ready,
    output logic [7:0]        timestep,
    output logic              err
`ifdef LSTM_STATE_BUF_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [1:0] ST_DATA  = 2'b01;
    localparam logic [1:0] ST_LAST  = 2'b10;
    localparam logic [1:0] ST_CLEAR = 2'b11;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_NEURONS - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_RUN,
        S_WAIT_RD,
        S_WAIT_WR,
        S_SWAP
    } state_t;

    state_t state, state_nx;

    logic [2*XLEN-1:0] mem [2][NUM_NEURONS];
    logic [2*XLEN-1:0] rd_word;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              wr_done, rd_done;
    logic              bank_sel, zero_bank;

    logic beat, is_last, clear;
    logic wr_acc, wr_drop, wr_bad, rd_acc, rd_fin;
    logic wr_done_nx, rd_done_nx;

    assign rd_word = mem[~bank_sel][rd_ptr];

    always_comb begin
        beat       = (wr_status == ST_DATA) || (wr_status == ST_LAST);
        is_last    = (wr_status == ST_LAST);
        clear      = (wr_status == ST_CLEAR);
        wr_acc     = beat && !wr_done && (state != S_SWAP);
        wr_drop    = beat && !wr_acc;
        // LAST must land on the final neuron; DATA must not
        wr_bad     = wr_acc && (is_last ? (wr_ptr != LAST_PTR) : (wr_ptr == LAST_PTR));
        rd_acc     = rd_en && ts_ready && !rd_done && !clear;
        rd_fin     = rd_acc && (rd_ptr == LAST_PTR);
        wr_done_nx = wr_done || (wr_acc && is_last);
        rd_done_nx = rd_done || rd_fin;

        state_nx = state;
        if (clear) begin
            state_nx = S_INIT;
        end else begin
            case (state)
                S_INIT:    if (beat || rd_en) state_nx = S_RUN;
                S_RUN: begin
                    if (wr_done_nx && rd_done_nx) state_nx = S_SWAP;
                    else if (wr_done_nx)          state_nx = S_WAIT_RD;
                    else if (rd_done_nx)          state_nx = S_WAIT_WR;
                end
                S_WAIT_RD: if (rd_done_nx) state_nx = S_SWAP;
                S_WAIT_WR: if (wr_done_nx) state_nx = S_SWAP;
                S_SWAP:    state_nx = S_RUN;
                default:   state_nx = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_INIT;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;
            bank_sel  <= 1'b0;
            zero_bank <= 1'b1;
            timestep  <= 8'd0;
            err       <= 1'b0;
            ts_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_c      <= '0;
            rd_h      <= '0;
        end else begin
            state    <= state_nx;
            ts_ready <= (state_nx == S_INIT) || (state_nx == S_RUN) || (state_nx == S_WAIT_RD);
            rd_valid <= rd_acc;
            rd_last  <= rd_fin;
            if (rd_acc) begin
                rd_c <= zero_bank ? '0 : rd_word[2*XLEN-1:XLEN];
                rd_h <= zero_bank ? '0 : rd_word[XLEN-1:0];
            end

            if (clear) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                wr_done   <= 1'b0;
                rd_done   <= 1'b0;
                zero_bank <= 1'b1;
                timestep  <= 8'd0;
                err       <= 1'b0;
            end else if (state == S_SWAP) begin
                bank_sel  <= ~bank_sel;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                wr_done   <= 1'b0;
                rd_done   <= 1'b0;
                zero_bank <= 1'b0;
                timestep  <= timestep + 8'd1;
                if (beat) err <= 1'b1;
            end else begin
                if (wr_drop || wr_bad) err <= 1'b1;
                if (wr_acc) begin
                    if (wr_ptr != LAST_PTR) wr_ptr <= wr_ptr + 1'b1;
                    if (is_last) wr_done <= 1'b1;
                end
                if (rd_acc && (rd_ptr != LAST_PTR)) rd_ptr <= rd_ptr + 1'b1;
                if (rd_fin) rd_done <= 1'b1;
            end
        end
    end

    // Storage has no reset; the zero_bank flag masks stale contents on the first timestep.
    always_ff @(posedge clock) begin
        if (wr_acc) mem[bank_sel][wr_ptr] <= {wr_c, wr_h};
    end

`ifdef LSTM_STATE_BUF_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (clear) begin
            stall_cnt <= 16'd0;
        end else if (((state == S_WAIT_RD) || (state == S_WAIT_WR)) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
